// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, instruction register and decoder field split.
// Optional macro IFETCH_ALIGN_TRAP_EN: a misaligned branch target raises misalign and halts fetching.
module ifetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              incr,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
`ifdef IFETCH_ALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_imem_req;
  logic              r_instr_valid;
  logic              w_req_d;
  logic              w_valid_d;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_br_aligned;
  logic [31:0]       r_instr;
  logic              w_advance;
  logic              w_trap;

  assign w_pc_plus4   = r_pc + PC_STEP;
  assign w_br_aligned = {br_target[ADDR_W-1:2], 2'b00};
  assign w_advance    = (r_state == ST_EXEC) && !stall;

`ifdef IFETCH_ALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap   = w_advance && !incr && (br_target[1:0] != 2'b00);
  assign misalign = r_misalign;
`else
  logic w_unused_br_lsb;
  assign w_trap          = 1'b0;
  assign w_unused_br_lsb = ^br_target[1:0];
`endif

  // State register plus registered req/valid; async reset drops imem_req at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RESET;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_imem_req    <= w_req_d;
      r_instr_valid <= w_valid_d;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RESET: w_next_state = ST_FETCH;
      ST_FETCH: w_next_state = imem_ack ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        if (stall) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = w_trap ? ST_HALT : ST_FETCH;
        end
      end
`ifdef IFETCH_ALIGN_TRAP_EN
      ST_HALT:  w_next_state = ST_HALT;
`endif
      default:  w_next_state = ST_RESET;
    endcase
  end

  // Output decode from the upcoming state, so req/valid come straight from flops.
  always_comb begin
    w_req_d   = 1'b0;
    w_valid_d = 1'b0;
    case (w_next_state)
      ST_FETCH: w_req_d   = 1'b1;
      ST_EXEC:  w_valid_d = 1'b1;
      default: begin
        w_req_d   = 1'b0;
        w_valid_d = 1'b0;
      end
    endcase
  end

  // PC and instruction register; rdata is captured only on the FETCH ack cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      if ((r_state == ST_FETCH) && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (w_advance && !w_trap) begin
        r_pc <= incr ? w_pc_plus4 : w_br_aligned;
      end
    end
  end

`ifdef IFETCH_ALIGN_TRAP_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (w_trap) begin
      r_misalign <= 1'b1;
    end else begin
      r_misalign <= r_misalign;
    end
  end
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign opcode      = r_instr[6:0];
  assign funct3      = r_instr[14:12];
  assign funct7      = r_instr[31:25];
  assign rd          = r_instr[11:7];
  assign rs1         = r_instr[19:15];
  assign rs2         = r_instr[24:20];
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;

endmodule
